// File: rtl/vec_mux_pkg.sv
// ---------------------------------------------------------------------------
// vec_mux_pkg
// Shared types and defaults for the vector multiplexer/arbiter.
//   arb_mode_e  : channel selection policy (SEL_MODE = explicit select,
//                 RR_MODE = round-robin over valid channels)
//   out_state_e : occupancy of the single-entry output register
//   DEF_*       : default lane width, lanes per vector, channel count
//   sel_width() : select/index width, max(1, clog2(n))
// ---------------------------------------------------------------------------
package vec_mux_pkg;

    typedef enum logic {
        SEL_MODE = 1'b0,
        RR_MODE  = 1'b1
    } arb_mode_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_NUM_IN = 4;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vec_mux_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant: picks the first requesting channel
// searching upward from ptr+1 and wrapping to 0 (works for any NUM_IN,
// including non-powers of two).
//   req         : per-channel request
//   ptr         : index of the most recently granted channel
//   grant       : granted channel index (0 when grant_valid=0)
//   grant_valid : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import vec_mux_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SELW   = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SELW-1:0]   ptr,
    output logic [SELW-1:0]   grant,
    output logic              grant_valid
);

    // Two passes instead of a modulo index: first the channels above ptr,
    // then wrap around to the channels at or below ptr.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!grant_valid && req[i] && (i > int'(ptr))) begin
                grant       = SELW'(i);
                grant_valid = 1'b1;
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (!grant_valid && req[i] && (i <= int'(ptr))) begin
                grant       = SELW'(i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_mux_arb.sv
// ---------------------------------------------------------------------------
// vec_mux_arb
// Selects one of NUM_IN input vectors (DEPTH lanes of WIDTH bits) and
// captures it into a single-entry registered output stage with
// valid/ready handshaking on both sides. Throughput is one vector per
// cycle; latency from acceptance to out_valid is one cycle.
//
// Parameters:
//   WIDTH, DEPTH, NUM_IN (2..16), ARB_MODE (SEL_MODE | RR_MODE)
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_valid    : input vectors and per-channel valid
//   in_ready            : one-hot accept for the granted channel
//   sel                 : channel select (SEL_MODE only)
//   out_data/out_valid  : registered output vector and its valid
//   out_ready           : downstream accept
//   out_src             : channel index that produced out_data
//   lane_mask           : per-lane enable, only with VEC_MUX_LANE_MASK_EN
//
// Build option: define VEC_MUX_LANE_MASK_EN to add lane_mask; masked-off
// lanes load zero on transfer.
// ---------------------------------------------------------------------------
module vec_mux_arb
    import vec_mux_pkg::*;
#(
    parameter int        WIDTH    = DEF_WIDTH,
    parameter int        DEPTH    = DEF_DEPTH,
    parameter int        NUM_IN   = DEF_NUM_IN,
    parameter arb_mode_e ARB_MODE = SEL_MODE,
    localparam int       SELW     = sel_width(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data [0:NUM_IN-1][0:DEPTH-1],
    input  logic [NUM_IN-1:0] in_valid,
    output logic [NUM_IN-1:0] in_ready,
    input  logic [SELW-1:0]   sel,
    output logic [WIDTH-1:0]  out_data [0:DEPTH-1],
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SELW-1:0]   out_src
`ifdef VEC_MUX_LANE_MASK_EN
    ,
    input  logic [DEPTH-1:0]  lane_mask
`endif
);

    out_state_e        state_p1;
    out_state_e        state_nxt;
    logic [WIDTH-1:0]  data_p1   [0:DEPTH-1];
    logic [SELW-1:0]   src_p1;
    logic [WIDTH-1:0]  load_data [0:DEPTH-1];
    logic [DEPTH-1:0]  lane_en;
    logic [SELW-1:0]   grant_idx;
    logic              grant_vld;
    logic              load_en;
    logic              xfer;

    // The output register can take a new vector when it is empty or is
    // being drained this cycle. Reset blocks every transfer.
    assign load_en = (state_p1 == EMPTY) || out_ready;
    assign xfer    = load_en && grant_vld && !rst;

`ifdef VEC_MUX_LANE_MASK_EN
    assign lane_en = lane_mask;
`else
    assign lane_en = '1;
`endif

    generate
        if (ARB_MODE == RR_MODE) begin : g_rr
            logic [SELW-1:0] rr_ptr;
            logic            unused_sel;

            assign unused_sel = ^sel;

            rr_arbiter #(
                .NUM_IN (NUM_IN),
                .SELW   (SELW)
            ) u_rr_arbiter (
                .req         (in_valid),
                .ptr         (rr_ptr),
                .grant       (grant_idx),
                .grant_valid (grant_vld)
            );

            // Pointer starts at the last channel so channel 0 wins first;
            // it only moves when the granted vector is actually accepted.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_ptr <= SELW'(NUM_IN - 1);
                end else if (xfer) begin
                    rr_ptr <= grant_idx;
                end
            end
        end else begin : g_sel
            // Zero-extend valid to the full select range so an out-of-range
            // sel (non-power-of-two NUM_IN) reads as "not valid".
            logic [(1 << SELW)-1:0] valid_ext;

            always_comb begin
                valid_ext             = '0;
                valid_ext[NUM_IN-1:0] = in_valid;
            end

            assign grant_idx = sel;
            assign grant_vld = valid_ext[sel];
        end
    endgenerate

    // Granted-channel mux with per-lane gating.
    always_comb begin
        for (int l = 0; l < DEPTH; l++) begin
            load_data[l] = '0;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SELW'(i)) begin
                for (int l = 0; l < DEPTH; l++) begin
                    load_data[l] = lane_en[l] ? in_data[i][l] : '0;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (xfer && (grant_idx == SELW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // ---- p1: output register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < DEPTH; l++) begin
                data_p1[l] <= '0;
            end
            src_p1 <= '0;
        end else if (xfer) begin
            for (int l = 0; l < DEPTH; l++) begin
                data_p1[l] <= load_data[l];
            end
            src_p1 <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= EMPTY;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p1;
        case (state_p1)
            EMPTY:   if (xfer) state_nxt = FULL;
            FULL:    if (out_ready && !xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    assign out_data  = data_p1;
    assign out_src   = src_p1;
    assign out_valid = (state_p1 == FULL);

endmodule

// File: tb/tb_vec_mux_arb.sv
// ---------------------------------------------------------------------------
// tb_vec_mux_arb
// Bench for vec_mux_arb: a SEL_MODE instance (NUM_IN=4), an RR_MODE
// instance (NUM_IN=4) and a SEL_MODE instance with NUM_IN=3. Expected
// outputs are pushed to per-instance queues when a transfer is predicted
// and compared while the output register holds them.
// ---------------------------------------------------------------------------
module tb_vec_mux_arb;
    import vec_mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] lane_mask;
    int         checks = 0;
    int         errors = 0;

    // SEL_MODE, NUM_IN=4
    logic [31:0] sd    [0:3][0:3];
    logic [31:0] s_out [0:3];
    logic [3:0]  s_valid, s_ready;
    logic [1:0]  s_sel, s_src;
    logic        s_ovld, s_ordy;

    // RR_MODE, NUM_IN=4
    logic [31:0] rd    [0:3][0:3];
    logic [31:0] r_out [0:3];
    logic [3:0]  r_valid, r_ready;
    logic [1:0]  r_sel, r_src;
    logic        r_ovld, r_ordy;

    // SEL_MODE, NUM_IN=3
    logic [31:0] td    [0:2][0:3];
    logic [31:0] t_out [0:3];
    logic [2:0]  t_valid, t_ready;
    logic [1:0]  t_sel, t_src;
    logic        t_ovld, t_ordy;

    vec_mux_arb #(.WIDTH(32), .DEPTH(4), .NUM_IN(4), .ARB_MODE(SEL_MODE)) u_sel (
        .clk(clk), .rst(rst), .in_data(sd), .in_valid(s_valid), .in_ready(s_ready),
        .sel(s_sel), .out_data(s_out), .out_valid(s_ovld), .out_ready(s_ordy),
        .out_src(s_src)
`ifdef VEC_MUX_LANE_MASK_EN
        , .lane_mask(lane_mask)
`endif
    );

    vec_mux_arb #(.WIDTH(32), .DEPTH(4), .NUM_IN(4), .ARB_MODE(RR_MODE)) u_rr (
        .clk(clk), .rst(rst), .in_data(rd), .in_valid(r_valid), .in_ready(r_ready),
        .sel(r_sel), .out_data(r_out), .out_valid(r_ovld), .out_ready(r_ordy),
        .out_src(r_src)
`ifdef VEC_MUX_LANE_MASK_EN
        , .lane_mask(lane_mask)
`endif
    );

    vec_mux_arb #(.WIDTH(32), .DEPTH(4), .NUM_IN(3), .ARB_MODE(SEL_MODE)) u_sel3 (
        .clk(clk), .rst(rst), .in_data(td), .in_valid(t_valid), .in_ready(t_ready),
        .sel(t_sel), .out_data(t_out), .out_valid(t_ovld), .out_ready(t_ordy),
        .out_src(t_src)
`ifdef VEC_MUX_LANE_MASK_EN
        , .lane_mask(lane_mask)
`endif
    );

    typedef struct packed {
        logic [1:0]       src;
        logic [3:0][31:0] d;
    } exp_t;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] rdy;
    } vec_t;

    exp_t       sq[$];
    exp_t       rq[$];
    logic [1:0] rm_ptr;
    vec_t       tbl [10];
    int         exp_seq [5];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fill_sd(input int tag);
        for (int c = 0; c < 4; c++)
            for (int l = 0; l < 4; l++)
                sd[c][l] = 32'h1000_0000 + 32'(tag * 256 + c * 16 + l);
    endtask

    // Model of the round-robin pick: rotate so bit 0 is channel ptr+1.
    function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [2:0] res;
        dbl = {v, v};
        rot = 4'(dbl >> (int'(p) + 1));
        res = 3'b000;
        for (int j = 0; j < 4; j++) begin
            if (!res[2] && rot[j]) res = {1'b1, 2'(int'(p) + 1 + j)};
        end
        return res;
    endfunction

    task automatic step_sel(input logic [1:0] s, input logic [3:0] v, input logic r,
                            input logic [3:0] exp_rdy, input string nm);
        exp_t e;
        logic xfer;
        s_sel = s; s_valid = v; s_ordy = r;
        #1;
        chk({nm, ".in_ready"}, 128'(s_ready), 128'(exp_rdy));
        xfer = ((sq.size() == 0) || r) && v[s];
        e = '0;
        if (xfer) begin
            e.src = s;
            for (int l = 0; l < 4; l++) e.d[l] = lane_mask[l] ? sd[s][l] : 32'd0;
        end
        @(posedge clk); #1;
        if ((sq.size() != 0) && r) void'(sq.pop_front());
        if (xfer) sq.push_back(e);
        chk({nm, ".out_valid"}, 128'(s_ovld), 128'(sq.size() != 0));
        if (sq.size() != 0) begin
            chk({nm, ".out_src"}, 128'(s_src), 128'(sq[0].src));
            chk({nm, ".out_data"}, 128'({s_out[3], s_out[2], s_out[1], s_out[0]}), 128'(sq[0].d));
        end
    endtask

    task automatic step_rr(input logic [3:0] v, input logic r, input string nm);
        exp_t       e;
        logic [2:0] pk;
        logic       xfer;
        r_valid = v; r_ordy = r;
        #1;
        pk   = rr_pick(v, rm_ptr);
        xfer = ((rq.size() == 0) || r) && pk[2];
        chk({nm, ".in_ready"}, 128'(r_ready), xfer ? 128'(4'b0001 << pk[1:0]) : 128'd0);
        e = '0;
        if (xfer) begin
            e.src = pk[1:0];
            for (int l = 0; l < 4; l++) e.d[l] = lane_mask[l] ? rd[pk[1:0]][l] : 32'd0;
        end
        @(posedge clk); #1;
        if ((rq.size() != 0) && r) void'(rq.pop_front());
        if (xfer) begin
            rq.push_back(e);
            rm_ptr = pk[1:0];
        end
        chk({nm, ".out_valid"}, 128'(r_ovld), 128'(rq.size() != 0));
        if (rq.size() != 0) begin
            chk({nm, ".out_src"}, 128'(r_src), 128'(rq[0].src));
            chk({nm, ".out_data"}, 128'({r_out[3], r_out[2], r_out[1], r_out[0]}), 128'(rq[0].d));
        end
    endtask

    // One reset cycle with every channel valid and outputs stalled.
    task automatic do_reset(input string nm);
        rst = 1'b1;
        s_valid = '1; s_ordy = 1'b0; s_sel = 2'd0;
        r_valid = '1; r_ordy = 1'b0;
        t_valid = '1; t_ordy = 1'b0; t_sel = 2'd0;
        #1;
        chk({nm, ".s_in_ready"}, 128'(s_ready), 128'd0);
        chk({nm, ".r_in_ready"}, 128'(r_ready), 128'd0);
        chk({nm, ".t_in_ready"}, 128'(t_ready), 128'd0);
        @(posedge clk); #1;
        chk({nm, ".s_out_valid"}, 128'(s_ovld), 128'd0);
        chk({nm, ".s_out_src"}, 128'(s_src), 128'd0);
        chk({nm, ".s_out_data"}, 128'({s_out[3], s_out[2], s_out[1], s_out[0]}), 128'd0);
        chk({nm, ".r_out_valid"}, 128'(r_ovld), 128'd0);
        chk({nm, ".r_out_data"}, 128'({r_out[3], r_out[2], r_out[1], r_out[0]}), 128'd0);
        chk({nm, ".t_out_valid"}, 128'(t_ovld), 128'd0);
        rst = 1'b0;
        s_valid = '0; r_valid = '0; t_valid = '0;
        sq.delete();
        rq.delete();
        rm_ptr = 2'd3;
    endtask

    initial begin
        rst = 1'b1;
        lane_mask = 4'hF;
        s_valid = '0; s_sel = '0; s_ordy = 1'b0;
        r_valid = '0; r_sel = '0; r_ordy = 1'b0;
        t_valid = '0; t_sel = '0; t_ordy = 1'b0;
        rm_ptr = 2'd3;
        fill_sd(0);
        for (int c = 0; c < 4; c++)
            for (int l = 0; l < 4; l++)
                rd[c][l] = 32'hA000_0000 + 32'(c * 16 + l);
        for (int c = 0; c < 3; c++)
            for (int l = 0; l < 4; l++)
                td[c][l] = 32'hC000_0000 + 32'(c * 16 + l);

        tbl[0] = '{2'd0, 4'b0001, 1'b1, 4'b0001};
        tbl[1] = '{2'd1, 4'b0001, 1'b1, 4'b0000};
        tbl[2] = '{2'd3, 4'b1000, 1'b0, 4'b1000};
        tbl[3] = '{2'd0, 4'b1111, 1'b0, 4'b0000};
        tbl[4] = '{2'd0, 4'b1111, 1'b0, 4'b0000};
        tbl[5] = '{2'd1, 4'b1111, 1'b1, 4'b0010};
        tbl[6] = '{2'd2, 4'b1011, 1'b1, 4'b0000};
        tbl[7] = '{2'd2, 4'b0000, 1'b1, 4'b0000};
        tbl[8] = '{2'd3, 4'b1111, 1'b1, 4'b1000};
        tbl[9] = '{2'd3, 4'b1111, 1'b1, 4'b1000};
        exp_seq = '{0, 1, 2, 3, 0};

        do_reset("reset0");

        // Single transfer from channel 2 with known data.
        sd[2][0] = 32'd1; sd[2][1] = 32'd2; sd[2][2] = 32'd3; sd[2][3] = 32'd4;
        step_sel(2'd2, 4'b0100, 1'b1, 4'b0100, "basic");
        chk("basic.const_data", 128'({s_out[3], s_out[2], s_out[1], s_out[0]}),
            128'({32'd4, 32'd3, 32'd2, 32'd1}));
        chk("basic.const_src", 128'(s_src), 128'd2);

        do_reset("reset1");
        for (int i = 0; i < 10; i++) begin
            fill_sd(i + 1);
            step_sel(tbl[i].sel, tbl[i].valid, tbl[i].ordy, tbl[i].rdy, $sformatf("tbl%0d", i));
        end

        // Held output must ignore changing sel and data.
        for (int k = 0; k < 3; k++) begin
            fill_sd(20 + k);
            step_sel(2'(k), 4'b1111, 1'b0, 4'b0000, $sformatf("stall%0d", k));
        end
        chk("stall.const_src", 128'(s_src), 128'd3);
        fill_sd(30);
        step_sel(2'd0, 4'b0001, 1'b1, 4'b0001, "drain");

`ifdef VEC_MUX_LANE_MASK_EN
        lane_mask = 4'b0101;
        sd[1][0] = 32'hAAAA_0001; sd[1][1] = 32'hBBBB_0002;
        sd[1][2] = 32'hCCCC_0003; sd[1][3] = 32'hDDDD_0004;
        step_sel(2'd1, 4'b0010, 1'b1, 4'b0010, "mask");
        chk("mask.const_data", 128'({s_out[3], s_out[2], s_out[1], s_out[0]}),
            128'({32'd0, 32'hCCCC_0003, 32'd0, 32'hAAAA_0001}));
        lane_mask = 4'hF;
`endif

        do_reset("reset2");
        for (int k = 0; k < 5; k++) begin
            step_rr(4'b1111, 1'b1, $sformatf("rr_all%0d", k));
            chk($sformatf("rr_seq%0d", k), 128'(r_src), 128'(exp_seq[k]));
        end
        for (int k = 0; k < 3; k++) begin
            step_rr(4'b1010, 1'b1, $sformatf("rr_part%0d", k));
        end
        step_rr(4'b1111, 1'b0, "rr_stall");
        step_rr(4'b1111, 1'b1, "rr_resume");
        chk("rr_resume.const_src", 128'(r_src), 128'd2);
        step_rr(4'b1111, 1'b0, "rr_hold");

        // Reset while holding a stalled vector, then restart priority.
        do_reset("reset_mid");
        step_rr(4'b1111, 1'b1, "rr_after_rst");
        chk("rr_after_rst.const_src", 128'(r_src), 128'd0);

        // NUM_IN=3: select value 3 has no channel.
        t_sel = 2'd3; t_valid = 3'b111; t_ordy = 1'b1;
        #1;
        chk("sel3.oob_ready", 128'(t_ready), 128'd0);
        @(posedge clk); #1;
        chk("sel3.oob_valid", 128'(t_ovld), 128'd0);
        t_sel = 2'd2; t_valid = 3'b100;
        #1;
        chk("sel3.ch2_ready", 128'(t_ready), 128'b100);
        @(posedge clk); #1;
        chk("sel3.ch2_valid", 128'(t_ovld), 128'd1);
        chk("sel3.ch2_src", 128'(t_src), 128'd2);
        chk("sel3.ch2_data", 128'(t_out[0]), 128'(td[2][0]));
        t_sel = 2'd0; t_valid = 3'b001;
        #1;
        chk("sel3.ch0_ready", 128'(t_ready), 128'b001);
        @(posedge clk); #1;
        chk("sel3.ch0_src", 128'(t_src), 128'd0);
        chk("sel3.ch0_data", 128'(t_out[3]), 128'(td[0][3]));
        t_sel = 2'd3; t_valid = 3'b111;
        #1;
        chk("sel3.oob2_ready", 128'(t_ready), 128'd0);
        @(posedge clk); #1;
        chk("sel3.drain_valid", 128'(t_ovld), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vec_mux_arb.md
VEC_MUX_ARB -- requirements
Module: vec_mux_arb

Interface
REQ-001 Parameter: WIDTH, default 32, bits per lane.
REQ-002 Parameter: DEPTH, default 4, lanes per vector.
REQ-003 Parameter: NUM_IN, default 4, number of input vector channels (2..16).
REQ-004 Parameter: ARB_MODE, default SEL_MODE, channel selection policy (SEL_MODE or RR_MODE).
REQ-005 Port: clk  input  1  single clock, all state on rising edge.
REQ-006 Port: rst  input  1  synchronous, active-high reset.
REQ-007 Port: in_data  input  NUM_IN x DEPTH x WIDTH  unpacked array of input vectors, [0:NUM_IN-1][0:DEPTH-1].
REQ-008 Port: in_valid  input  NUM_IN  per-channel valid.
REQ-009 Port: in_ready  output  NUM_IN  per-channel accept.
REQ-010 Port: sel  input  SELW = max(1, clog2(NUM_IN))  channel select, used in SEL_MODE only.
REQ-011 Port: out_data  output  DEPTH x WIDTH  registered output vector, [0:DEPTH-1].
REQ-012 Port: out_valid  output  1  out_data holds a vector.
REQ-013 Port: out_ready  input  1  downstream accept.
REQ-014 Port: out_src  output  SELW  index of the channel that produced out_data.
REQ-015 Port: lane_mask  input  DEPTH  per-lane enable; present only when VEC_MUX_LANE_MASK_EN is defined.

Function
REQ-016 Output stage SHALL be a single-entry register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 load_en SHALL equal !out_valid || out_ready; transfers occur only when load_en=1 and a grant exists.
REQ-018 SEL_MODE: grant SHALL be sel when sel < NUM_IN and in_valid[sel]=1; otherwise no grant.
REQ-019 RR_MODE: grant SHALL be the first valid channel searching from rr_ptr+1 upward, modulo NUM_IN.
REQ-020 rr_ptr SHALL update to the granted index only on an accepted transfer.
REQ-021 in_ready[i] SHALL be 1 only if load_en=1, a grant exists, and i is the granted index; all other in_ready bits are 0.
REQ-022 On transfer, out_data, out_src and out_valid=1 SHALL update at the next edge; the latency is 1 cycle.
REQ-023 Transitions: EMPTY->FULL on transfer; FULL->EMPTY when out_ready=1 and there is no transfer; FULL->FULL when out_ready=1 and there is a transfer (back-to-back, 1 vector/cycle), or when out_ready=0.
REQ-024 While FULL and out_ready=0, out_data and out_src SHALL remain stable regardless of sel, in_valid or in_data.
REQ-025 If no channel is valid, no register SHALL change except the out_valid clear per REQ-023.
REQ-026 Channel indices SHALL wrap from NUM_IN-1 to 0, including for non-power-of-two NUM_IN.

Reset
REQ-027 When rst=1 at an edge: out_valid=0, out_data all lanes 0, out_src=0, rr_ptr=NUM_IN-1 (channel 0 highest priority first).
REQ-028 in_ready SHALL be 0 while rst=1; a vector held mid-stall SHALL be discarded.

Configuration
REQ-029 With VEC_MUX_LANE_MASK_EN defined, lanes whose lane_mask bit is 0 SHALL load 0 on transfer, sampled in the same cycle as the data.
REQ-030 Without VEC_MUX_LANE_MASK_EN, the lane_mask port SHALL be absent and all lanes pass unmodified.

Structure
REQ-031 Package vec_mux_pkg SHALL hold the arb_mode_e enum (SEL_MODE=0, RR_MODE=1) and the default WIDTH/DEPTH constants.
REQ-032 Round-robin grant logic SHALL reside in sub-module rr_arbiter (req, ptr -> grant index, grant_valid), instantiated only in RR_MODE.

Verification
REQ-033 SEL_MODE, NUM_IN=4: sel=2, in_valid=4'b0100, in_data[2]={1,2,3,4}, out_ready=1 -> in_ready=4'b0100; the next cycle has out_valid=1, out_data={1,2,3,4}, out_src=2.
REQ-034 Stall: FULL, out_ready=0 for 3 cycles while sel and in_data change -> out_data and out_src are unchanged and in_ready=0.
REQ-035 RR_MODE, all 4 channels valid, out_ready=1 -> out_src sequence is 0,1,2,3,0 on consecutive cycles (throughput 1/cycle).
REQ-036 rst asserted while FULL with out_ready=0 -> the next cycle has out_valid=0 and out_data=0; after release, the first RR grant goes to channel 0.
REQ-037 With VEC_MUX_LANE_MASK_EN: lane_mask=4'b0101 and data {A,B,C,D} -> out_data {A,0,C,0}.
REQ-038 NUM_IN=3, SEL_MODE, sel=3 -> no grant, in_ready=0, and out_valid stays 0.
